// File: rtl/rst_btn_conditioner.sv
// Reset push-button conditioner: 2-flop sync, debounce, minimum-width stretch, clean release.
// Optional RST_POR_STRETCH_EN: board reset asserts res_out and stretches its release.
module rst_btn_conditioner #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int MIN_PULSE_CYCLES = 16,
    parameter int CNT_W            = 20
) (
    input  logic       clk_100M,
    input  logic       res,
    input  logic       btn_raw,
    output logic       res_out,
    output logic [7:0] press_count,
    output logic [2:0] fsm_state
);

`ifdef RST_POR_STRETCH_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DB_ON  = 3'd1,
        ASSERT = 3'd2,
        DB_OFF = 3'd3,
        POR    = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DB_ON  = 3'd1,
        ASSERT = 3'd2,
        DB_OFF = 3'd3
    } state_t;
`endif

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MP_LAST = CNT_W'(MIN_PULSE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sync;
    logic             btn_sync;

    always_ff @(posedge clk_100M or negedge res) begin
        if (!res) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], btn_raw};
        end
    end

    assign btn_sync  = sync[1];
    assign fsm_state = state;

    always_ff @(posedge clk_100M or negedge res) begin
        if (!res) begin
            cnt         <= '0;
            press_count <= '0;
`ifdef RST_POR_STRETCH_EN
            state       <= POR;
            res_out     <= 1'b1;
`else
            state       <= IDLE;
            res_out     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state <= DB_ON;
                        cnt   <= '0;
                    end
                end
                DB_ON: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state   <= ASSERT;
                        cnt     <= '0;
                        res_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Counter parks at its terminal value while the button is held.
                ASSERT: begin
                    if (cnt == MP_LAST) begin
                        if (!btn_sync) begin
                            state <= DB_OFF;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DB_OFF: begin
                    if (btn_sync) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        res_out     <= 1'b0;
                        press_count <= press_count + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef RST_POR_STRETCH_EN
                POR: begin
                    if (cnt == MP_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        res_out <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    res_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_btn_conditioner.sv
// Scoreboard bench for rst_btn_conditioner: directed presses, expected res_out edges queued.
// Build with +define+RST_POR_STRETCH_EN to exercise the power-on stretch.
module tb_rst_btn_conditioner;

    localparam int DB = 8;
    localparam int MP = 4;
`ifdef RST_POR_STRETCH_EN
    localparam int POR_EN = 1;
`else
    localparam int POR_EN = 0;
`endif

    logic       clk_100M = 1'b0;
    logic       res      = 1'b0;
    logic       btn_raw  = 1'b0;
    logic       res_out;
    logic [7:0] press_count;
    logic [2:0] fsm_state;

    typedef struct {
        string      name;
        logic       val;
        int         cyc;
        logic [7:0] pc;
        logic [2:0] st;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    logic prev;
    int   c;
    int   r;

    rst_btn_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .MIN_PULSE_CYCLES(MP),
        .CNT_W           (20)
    ) dut (
        .clk_100M   (clk_100M),
        .res        (res),
        .btn_raw    (btn_raw),
        .res_out    (res_out),
        .press_count(press_count),
        .fsm_state  (fsm_state)
    );

    always #10 clk_100M = ~clk_100M;

    always @(posedge clk_100M) cyc++;

    // Every res_out transition must match the next queued expectation.
    always @(negedge clk_100M) begin : mon
        exp_t e;
        if (mon_en && res_out !== prev) begin
            prev = res_out;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_edge: res_out=%0b at cyc %0d, no edge required",
                         res_out, cyc);
            end else begin
                e = q.pop_front();
                if (res_out !== e.val || cyc != e.cyc ||
                    press_count !== e.pc || fsm_state !== e.st) begin
                    fails++;
                    $display("FAIL %s: got res_out=%0b cyc=%0d pc=%0d st=%0d, required res_out=%0b cyc=%0d pc=%0d st=%0d",
                             e.name, res_out, cyc, press_count, fsm_state,
                             e.val, e.cyc, e.pc, e.st);
                end
            end
        end
    end

    task automatic push(input string name, input logic val, input int at,
                        input logic [7:0] pc, input logic [2:0] st);
        exp_t e;
        e.name = name;
        e.val  = val;
        e.cyc  = at;
        e.pc   = pc;
        e.st   = st;
        q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_100M);
    endtask

    initial begin
        wait_cyc(3);
        #1;
        check("rst_res_out", int'(res_out), POR_EN);
        check("rst_state", int'(fsm_state), POR_EN ? 4 : 0);
        check("rst_press_count", int'(press_count), 0);
        prev   = res_out;
        mon_en = 1'b1;

        @(negedge clk_100M);
        c = cyc;
        if (POR_EN != 0) push("por_release", 1'b0, c + MP, 8'd0, 3'd0);
        res = 1'b1;
        wait_cyc(10);

        // Short bounce: never reaches the debounce terminal count.
        btn_raw = 1'b1;
        wait_cyc(5);
        btn_raw = 1'b0;
        wait_cyc(20);
        #1;
        check("bounce_state", int'(fsm_state), 0);
        check("bounce_press_count", int'(press_count), 0);
        check("bounce_res_out", int'(res_out), 0);

        // Clean press held 40 cycles: rise at +11, fall 11 after release.
        @(negedge clk_100M);
        c = cyc;
        push("clean_rise", 1'b1, c + 11, 8'd0, 3'd2);
        push("clean_fall", 1'b0, c + 51, 8'd1, 3'd0);
        btn_raw = 1'b1;
        wait_cyc(40);
        btn_raw = 1'b0;
        wait_cyc(20);

        // Release bounce: last low run starts at +25, 8 stable samples end at +35.
        c = cyc;
        push("relb_rise", 1'b1, c + 11, 8'd1, 3'd2);
        push("relb_fall", 1'b0, c + 35, 8'd2, 3'd0);
        btn_raw = 1'b1;
        wait_cyc(20);
        btn_raw = 1'b0;
        wait_cyc(3);
        btn_raw = 1'b1;
        wait_cyc(2);
        btn_raw = 1'b0;
        wait_cyc(20);

        // Minimum pulse: released as ASSERT is entered, leaves ASSERT at +15.
        c = cyc;
        push("minp_rise", 1'b1, c + 11, 8'd2, 3'd2);
        push("minp_fall", 1'b0, c + 23, 8'd3, 3'd0);
        btn_raw = 1'b1;
        wait_cyc(11);
        btn_raw = 1'b0;
        wait_cyc(20);

        // Reset while in ASSERT aborts the press.
        c = cyc;
        push("rmid_rise", 1'b1, c + 11, 8'd3, 3'd2);
        btn_raw = 1'b1;
        wait_cyc(15);
        if (POR_EN == 0) push("rmid_abort", 1'b0, c + 16, 8'd0, 3'd0);
        #5;
        res = 1'b0;
        #1;
        check("rmid_res_out", int'(res_out), POR_EN);
        check("rmid_state", int'(fsm_state), POR_EN ? 4 : 0);
        check("rmid_press_count", int'(press_count), 0);
        btn_raw = 1'b0;
        wait_cyc(2);
        r = cyc;
        if (POR_EN != 0) push("rmid_por_release", 1'b0, r + MP, 8'd0, 3'd0);
        res = 1'b1;
        wait_cyc(12);
        #1;
        check("final_state", int'(fsm_state), 0);
        check("final_press_count", int'(press_count), 0);
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
